ksa_sub_pipe: RTL and testbench
===============================

# ksa_sub_pipe

Pipelined Kogge-Stone subtractor computing a − b on WIDTH-bit operands with valid/ready handshakes on both sides. It is the subtract counterpart of the KSA adder datapath: the B operand is inverted and an implicit carry-in of 1 is applied. One Kogge-Stone prefix level is evaluated per pipeline stage, so throughput is one result per clock. Downstream compare and decrement logic reads the unsigned borrow and signed overflow flags.

## Interface
- WIDTH, 16: operand width; a power of two, ≥ 4.
- LEVELS, $clog2(WIDTH): number of prefix levels (derived; do not override).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a and b are presented.
- in_ready  out  1  pipeline accepts operands this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  diff, borrow and overflow are valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow  out  1  1 when a < b unsigned, i.e. the inverse of the final carry.
- overflow  out  1  signed two's-complement overflow of a − b.

## Operation
- Stage 0 (PG): computes per-bit p[i] = a[i] ^ ~b[i] and g[i] = a[i] & ~b[i].
  - Carry-in 1 is folded in: g[0] = g[0] | p[0].
  - Registers p, g, the original p (for the sum), a[WIDTH-1] and b[WIDTH-1].
- Stages 1..LEVELS: level k combines bit i with bit i − 2^(k−1) when i ≥ 2^(k−1).
  - G = Gh | (Ph & Gl), P = Ph & Pl.
  - Bits below 2^(k−1) pass through unchanged.
  - The original p vector and both operand MSBs travel along with the data.
- Final stage (SUM): carry into bit i is 1 for i = 0 and G[i−1] for i > 0.
  - diff[i] = p_orig[i] ^ carry_in[i].
  - borrow = ~G[WIDTH−1].
  - overflow = (a_msb ^ b_msb) & (diff[WIDTH−1] ^ a_msb).
  - diff, borrow and overflow are registered as the outputs.
- Each stage holds a valid bit.
- Global stall: advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance = 1, every stage loads from its predecessor and stage 0 loads in_valid & in_ready.
  - When advance = 0, all stages hold.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

## Timing
- Latency is LEVELS + 2 cycles from accept to out_valid, with no stalls. For WIDTH = 16 this is 6.
- Throughput is 1 result per cycle while out_ready = 1.
- Reset (asynchronous, rst_n = 0):
  - All stage valid bits clear, so out_valid = 0.
  - diff = 0, borrow = 0, overflow = 0.
  - in_ready = 1 from the first cycle after release, because out_valid = 0.
  - Data registers other than the outputs need no reset.
- Reset mid-operation: every in-flight result is discarded. None may appear after rst_n rises.
- Output hold: while out_valid = 1 and out_ready = 0, diff, borrow and overflow stay stable.
- Bubbles: in_valid = 0 inserts a bubble. Bubbles propagate and are dropped only by an advance. They do not collapse while stalled.
- Accept and deliver in the same cycle (out_valid & out_ready & in_valid & in_ready) is legal and loses no data.
- Boundary values:
  - a = b gives diff = 0, borrow = 0, overflow = 0.
  - b = 0 gives diff = a, borrow = 0.

## Structure
- Package ksa_pkg holds:
  - the level-count function (clog2 wrapper);
  - a pg_t struct {p, g} for prefix-stage data;
  - a stage-record type {valid, G, P, p_orig, a_msb, b_msb}.
- Sub-module ksa_pg_cell: inputs p_hi, g_hi, p_lo, g_lo; outputs p_out, g_out. It is combinational and instantiated per bit per level inside a generate loop.
- The top level contains the PG logic, the generate-built prefix stages, the SUM stage and the stall logic.

## Test plan
- 0x0005 − 0x0003, out_ready = 1 → 6 cycles later diff = 0x0002, borrow = 0, overflow = 0.
- 0x0000 − 0x0001 → diff = 0xFFFF, borrow = 1, overflow = 0.
- 0x8000 − 0x0001 → diff = 0x7FFF, borrow = 0, overflow = 1.
- 0x7FFF − 0xFFFF → diff = 0x8000, borrow = 1, overflow = 1.
- Stream 20 back-to-back random pairs while holding out_ready = 0 for cycles 8–11:
  - in_ready = 0 during the stall;
  - results arrive in order, with none lost or duplicated;
  - all results match a reference model.
- Assert rst_n = 0 while 3 results are in flight → out_valid = 0 immediately; after release no stale results emerge, and a new 0x0009 − 0x0004 yields 0x0005.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and helpers for the Kogge-Stone subtractor pipeline.
package ksa_pkg;

    // Record types are sized by this width; the top-level WIDTH must match it.
    localparam int KSA_WIDTH = 16;

    function automatic int ksa_levels(input int width);
        return $clog2(width);
    endfunction

    // Propagate/generate pair for one prefix stage.
    typedef struct packed {
        logic [KSA_WIDTH-1:0] p;
        logic [KSA_WIDTH-1:0] g;
    } pg_t;

    // One pipeline stage: group P/G so far, the untouched bitwise p for the
    // final sum, and the operand MSBs for the overflow flag.
    typedef struct packed {
        logic                 valid;
        logic [KSA_WIDTH-1:0] g;
        logic [KSA_WIDTH-1:0] p;
        logic [KSA_WIDTH-1:0] p_orig;
        logic                 a_msb;
        logic                 b_msb;
    } stage_t;

endpackage

// File: rtl/ksa_pg_cell.sv
// Kogge-Stone black cell: merges a higher group with the adjacent lower group.
module ksa_pg_cell (
    input  logic p_hi,
    input  logic g_hi,
    input  logic p_lo,
    input  logic g_lo,
    output logic p_out,
    output logic g_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b, one prefix level per stage,
// with a single global stall shared by every stage.
module ksa_sub_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH  = KSA_WIDTH,
    parameter int LEVELS = ksa_levels(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    stage_t                     st [0:LEVELS];
    pg_t                        pg0;
    logic [LEVELS:1][WIDTH-1:0] lvl_g;
    logic [LEVELS:1][WIDTH-1:0] lvl_p;
    logic [WIDTH-1:0]           carry;
    logic [WIDTH-1:0]           sum_d;
    logic                       borrow_d;
    logic                       overflow_d;
    logic                       advance;
    logic                       unused_last_p;

    // The whole pipe moves together whenever the output slot is free.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Bitwise PG of a + ~b; the +1 carry-in is folded into bit 0's generate.
    always_comb begin
        pg0.p    = a ^ ~b;
        pg0.g    = a & ~b;
        pg0.g[0] = pg0.g[0] | pg0.p[0];
    end

    // Prefix level k merges bit i with bit i - 2^(k-1); lower bits pass through.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int DIST = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_cell
                ksa_pg_cell u_cell (
                    .p_hi  (st[k-1].p[i]),
                    .g_hi  (st[k-1].g[i]),
                    .p_lo  (st[k-1].p[i-DIST]),
                    .g_lo  (st[k-1].g[i-DIST]),
                    .p_out (lvl_p[k][i]),
                    .g_out (lvl_g[k][i])
                );
            end else begin : g_pass
                assign lvl_p[k][i] = st[k-1].p[i];
                assign lvl_g[k][i] = st[k-1].g[i];
            end
        end
    end

    // Stage registers: PG stage plus one register per prefix level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                st[k] <= '0;
            end
        end else if (advance) begin
            st[0].valid  <= in_valid & in_ready;
            st[0].g      <= pg0.g;
            st[0].p      <= pg0.p;
            st[0].p_orig <= pg0.p;
            st[0].a_msb  <= a[WIDTH-1];
            st[0].b_msb  <= b[WIDTH-1];
            for (int k = 1; k <= LEVELS; k++) begin
                st[k].valid  <= st[k-1].valid;
                st[k].g      <= lvl_g[k];
                st[k].p      <= lvl_p[k];
                st[k].p_orig <= st[k-1].p_orig;
                st[k].a_msb  <= st[k-1].a_msb;
                st[k].b_msb  <= st[k-1].b_msb;
            end
        end
    end

    // Group P of the last level has no consumer; only its G matters.
    assign unused_last_p = ^st[LEVELS].p;

    // Sum: carry into bit i is the group generate of bits below it.
    always_comb begin
        carry      = {st[LEVELS].g[WIDTH-2:0], 1'b1};
        sum_d      = st[LEVELS].p_orig ^ carry;
        borrow_d   = ~st[LEVELS].g[WIDTH-1];
        overflow_d = (st[LEVELS].a_msb ^ st[LEVELS].b_msb) &
                     (sum_d[WIDTH-1] ^ st[LEVELS].a_msb);
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
        end else if (advance) begin
            out_valid <= st[LEVELS].valid;
            diff      <= sum_d;
            borrow    <= borrow_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Directed bench for ksa_sub_pipe: single vectors, stalled stream, mid-flight reset.
module tb_ksa_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;

    int          n_vec = 0;
    int          n_err = 0;
    int          sent, rcv, extra;
    bit          stall;
    logic [15:0] sa [20];
    logic [15:0] sb [20];
    logic [17:0] exp_r [20];

    ksa_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {borrow, overflow, diff}
    function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] d;
        d = x - y;
        return {x < y, (x[15] ^ y[15]) & (d[15] ^ x[15]), d};
    endfunction

    task automatic run_single(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] ed, input logic eb, input logic eo);
        int n;
        bit seen;
        @(posedge clk); #1;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
            if (out_valid) seen = 1'b1;
        end
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        chk({tag, "_overflow"}, overflow, eo);
        @(posedge clk); #1;
        chk({tag, "_single_out"}, out_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_diff", diff, 16'h0000);
        chk("rst_borrow", borrow, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed vectors
        run_single("v5m3",    16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_single("v0m1",    16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_single("v8000m1", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_single("v7fffmf", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
        run_single("eq",      16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0);
        run_single("bzero",   16'hC3E1, 16'h0000, 16'hC3E1, 1'b0, 1'b0);

        // Stream of 20 with a stall in cycles 8..11
        for (int i = 0; i < 20; i++) begin
            sa[i] = 16'($urandom_range(0, 65535));
            sb[i] = 16'($urandom_range(0, 65535));
            exp_r[i] = ref_sub(sa[i], sb[i]);
        end
        sent = 0; rcv = 0; extra = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 100 && rcv < 20; cyc++) begin
            stall = (cyc >= 8 && cyc <= 11);
            out_ready = !stall;
            in_valid = (sent < 20);
            if (sent < 20) begin
                a = sa[sent];
                b = sb[sent];
            end
            #1;
            if (stall) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_out_valid", out_valid, 1'b1);
            end
            if (out_valid) begin
                if (rcv < 20) begin
                    chk("stream_diff", diff, exp_r[rcv][15:0]);
                    chk("stream_overflow", overflow, exp_r[rcv][16]);
                    chk("stream_borrow", borrow, exp_r[rcv][17]);
                end else begin
                    extra++;
                end
                if (out_ready) rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", sent, 20);
        chk("stream_received", rcv, 20);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        chk("stream_extra", extra, 0);

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 + 16'(i);
            b = 16'h0001;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (n < 20 && !out_valid) begin
                @(posedge clk); #1;
                n++;
            end
            chk("flight_first_out", out_valid, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_diff", diff, 16'h0000);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("midrst_stale", extra, 0);
        run_single("post_rst", 16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
